// File: rtl/ddram_word_adapter.sv
// ddram_word_adapter
// Turns 32-bit word requests with byte enables into a sequence of single-byte
// strobe accesses on the DDR3 byte port. Read bytes are assembled into a
// 32-bit response word. Lanes are visited in ascending order and disabled
// lanes are skipped. Every output comes straight from a register.

module ddram_word_adapter #(
    parameter int LOW_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [27:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_din,
    output logic        resp_valid,
    output logic [31:0] resp_dout,
    output logic [27:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    // Last GAP count value; the gap lasts LOW_CYCLES cycles in total.
    localparam logic [3:0] GAP_LAST = 4'(LOW_CYCLES - 1);

    state_t      state_reg;
    logic [25:0] word_reg;
    logic        we_reg;
    logic [31:0] din_reg;
    logic [3:0]  pending_reg;
    logic [1:0]  lane_reg;
    logic [3:0]  gap_cnt_reg;

    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_dout_reg;
    logic [27:0] mem_addr_reg;
    logic [7:0]  mem_din_reg;
    logic        mem_we_reg;
    logic        mem_rd_reg;

    // Lane selection works on the incoming request while idle and on the
    // captured request afterwards, so the first lane is issued without an
    // extra cycle.
    logic        from_idle;
    logic        accept;
    logic [3:0]  pick_mask;
    logic [31:0] pick_din;
    logic [25:0] pick_word;
    logic        pick_we;
    logic [1:0]  pick_lane;
    logic [3:0]  pick_rest;
    logic [7:0]  pick_bytes [4];
    logic [7:0]  pick_byte;

    // Address bits [1:0] of the request carry no meaning for a word access.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign from_idle = (state_reg == ST_IDLE);
    assign accept    = req_valid && req_ready_reg;
    assign pick_mask = from_idle ? req_be : pending_reg;
    assign pick_din  = from_idle ? req_din : din_reg;
    assign pick_word = from_idle ? req_addr[27:2] : word_reg;
    assign pick_we   = from_idle ? req_we : we_reg;
    assign pick_rest = pick_mask & (pick_mask - 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_bytes
            assign pick_bytes[gi] = pick_din[8*gi +: 8];
        end
    endgenerate

    assign pick_byte = pick_bytes[pick_lane];

    // Lowest enabled lane of the candidate mask.
    always_comb begin
        pick_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pick_mask[i]) begin
                pick_lane = 2'(i);
            end
        end
    end

    // Main sequencer: request capture, byte strobes, gap timing, response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            word_reg       <= '0;
            we_reg         <= 1'b0;
            din_reg        <= '0;
            pending_reg    <= '0;
            lane_reg       <= '0;
            gap_cnt_reg    <= '0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_dout_reg  <= '0;
            mem_addr_reg   <= '0;
            mem_din_reg    <= '0;
            mem_we_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        word_reg      <= req_addr[27:2];
                        we_reg        <= req_we;
                        din_reg       <= req_din;
                        resp_dout_reg <= '0;
                        if (req_be == 4'd0) begin
                            resp_valid_reg <= 1'b1;
                            state_reg      <= ST_DONE;
                        end else begin
                            lane_reg     <= pick_lane;
                            pending_reg  <= pick_rest;
                            mem_addr_reg <= {pick_word, pick_lane};
                            mem_din_reg  <= pick_byte;
                            mem_we_reg   <= pick_we;
                            mem_rd_reg   <= !pick_we;
                            state_reg    <= ST_ISSUE;
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // The port signals that it took the edge by dropping ready.
                    if (!mem_ready) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        mem_we_reg  <= 1'b0;
                        mem_rd_reg  <= 1'b0;
                        gap_cnt_reg <= '0;
                        if (!we_reg) begin
                            resp_dout_reg[{lane_reg, 3'b000} +: 8] <= mem_dout;
                        end
                        state_reg <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        if (pending_reg != 4'd0) begin
                            lane_reg     <= pick_lane;
                            pending_reg  <= pick_rest;
                            mem_addr_reg <= {pick_word, pick_lane};
                            mem_din_reg  <= pick_byte;
                            mem_we_reg   <= pick_we;
                            mem_rd_reg   <= !pick_we;
                            state_reg    <= ST_ISSUE;
                        end else begin
                            resp_valid_reg <= 1'b1;
                            state_reg      <= ST_DONE;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    req_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_dout  = resp_dout_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_din    = mem_din_reg;
    assign mem_we     = mem_we_reg;
    assign mem_rd     = mem_rd_reg;

endmodule

// File: tb/tb_ddram_word_adapter.sv
// Testbench for ddram_word_adapter: randomized word requests against a
// behavioural byte-port model, with a scoreboard of expected byte accesses
// and responses checked by an independent monitor.

module tb_ddram_word_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance under main test (LOW_CYCLES = 2)
    logic        req_valid, req_ready, req_we;
    logic [27:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_din;
    logic        resp_valid;
    logic [31:0] resp_dout;
    logic [27:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_rd;
    logic [7:0]  mem_dout;
    logic        mem_ready;

    // Second instance for the LOW_CYCLES = 4 timing case
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [27:0] b_req_addr;
    logic [3:0]  b_req_be;
    logic [31:0] b_req_din;
    logic        b_resp_valid;
    logic [31:0] b_resp_dout;
    logic [27:0] b_mem_addr;
    logic [7:0]  b_mem_din;
    logic        b_mem_we, b_mem_rd;
    logic [7:0]  b_mem_dout;
    logic        b_mem_ready;

    ddram_word_adapter #(.LOW_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_din(req_din),
        .resp_valid(resp_valid), .resp_dout(resp_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    ddram_word_adapter #(.LOW_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_be(b_req_be), .req_din(b_req_din),
        .resp_valid(b_resp_valid), .resp_dout(b_resp_dout),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_we(b_mem_we), .mem_rd(b_mem_rd),
        .mem_dout(b_mem_dout), .mem_ready(b_mem_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-port model: an edge on either strobe is seen one cycle after it
    // rises; ready then stays low for the busy duration and the data is
    // addr[7:0]^0x5A.
    int   busy_force = 0;   // 0 = random busy 1..6
    logic prev_strobe;
    int   busy_cnt;
    always @(posedge clk) begin
        if (reset) begin
            mem_ready   <= 1'b1;
            mem_dout    <= 8'h00;
            prev_strobe <= 1'b0;
            busy_cnt    <= 0;
        end else begin
            prev_strobe <= mem_we | mem_rd;
            if ((mem_we | mem_rd) && !prev_strobe) begin
                mem_ready <= 1'b0;
                mem_dout  <= mem_addr[7:0] ^ 8'h5A;
                busy_cnt  <= (busy_force != 0) ? busy_force : int'($urandom_range(1, 6));
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) mem_ready <= 1'b1;
            end
        end
    end

    logic b_prev_strobe;
    int   b_busy_cnt;
    always @(posedge clk) begin
        if (reset) begin
            b_mem_ready   <= 1'b1;
            b_mem_dout    <= 8'h00;
            b_prev_strobe <= 1'b0;
            b_busy_cnt    <= 0;
        end else begin
            b_prev_strobe <= b_mem_we | b_mem_rd;
            if ((b_mem_we | b_mem_rd) && !b_prev_strobe) begin
                b_mem_ready <= 1'b0;
                b_mem_dout  <= b_mem_addr[7:0] ^ 8'h5A;
                b_busy_cnt  <= 1;
            end else if (b_busy_cnt > 0) begin
                b_busy_cnt <= b_busy_cnt - 1;
                if (b_busy_cnt == 1) b_mem_ready <= 1'b1;
            end
        end
    end

    typedef struct {
        logic        we;
        logic [27:0] addr;
        logic [7:0]  din;
    } acc_t;

    typedef struct {
        logic [31:0] dout;
        int          cyc;   // -1 when timing depends on random busy
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    // Monitor: strobe edges against expected accesses, gap length, responses.
    logic prev_we_s, prev_rd_s;
    int   low_cnt;
    bit   have_edge;
    int   acc_seen = 0;
    int   last_resp_cyc = -100;
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        if (reset) begin
            prev_we_s = 1'b0;
            prev_rd_s = 1'b0;
            have_edge = 1'b0;
            low_cnt   = 0;
        end else begin
            if ((mem_we && !prev_we_s) || (mem_rd && !prev_rd_s)) begin
                acc_seen++;
                check("strobe_exclusive", {31'd0, mem_we & mem_rd}, 32'd0);
                if (have_edge) check("gap_low_cycles", {31'd0, low_cnt >= 2}, 32'd1);
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_access: got we=%0b addr=0x%07h, expected no access",
                             mem_we, mem_addr);
                end else begin
                    a = exp_acc.pop_front();
                    check("acc_we", {31'd0, mem_we}, {31'd0, a.we});
                    check("acc_addr", {4'd0, mem_addr}, {4'd0, a.addr});
                    if (a.we) check("acc_din", {24'd0, mem_din}, {24'd0, a.din});
                end
                have_edge = 1'b1;
            end
            if (mem_we || mem_rd) low_cnt = 0;
            else low_cnt++;
            prev_we_s = mem_we;
            prev_rd_s = mem_rd;

            if (resp_valid) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid dout=0x%08h, expected none", resp_dout);
                end else begin
                    r = exp_rsp.pop_front();
                    check("resp_dout", resp_dout, r.dout);
                    if (r.cyc >= 0) check("resp_cycle", cyc, r.cyc);
                    $display("resp  cycle=%0d dout=0x%08h expected=0x%08h", cyc, resp_dout, r.dout);
                end
                last_resp_cyc = cyc;
            end
        end
    end

    // Issue one request; the reference result is pushed on acceptance.
    task automatic issue(input logic we, input logic [27:0] addr, input logic [3:0] be,
                         input logic [31:0] din, input bit b2b, input bit track_resp);
        int   waited = 0;
        int   nl = 0;
        int   acc_cyc;
        acc_t a;
        rsp_t r;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_din   = din;
        #1;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, expected 1", waited);
            req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (b2b) check("b2b_accept_cycle", acc_cyc, last_resp_cyc + 1);
        r.dout = 32'd0;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                a.we   = we;
                a.addr = {addr[27:2], 2'(n)};
                a.din  = din[8*n +: 8];
                exp_acc.push_back(a);
                nl++;
                if (!we) r.dout[8*n +: 8] = a.addr[7:0] ^ 8'h5A;
            end
        end
        if (be == 4'd0)            r.cyc = acc_cyc + 1;
        else if (busy_force == 1)  r.cyc = acc_cyc + 1 + nl * (3 + 2);
        else                       r.cyc = -1;
        if (track_resp) exp_rsp.push_back(r);
        $display("req   cycle=%0d we=%0b addr=0x%07h be=%04b din=0x%08h", acc_cyc, we, addr, be, din);
        @(posedge clk);
    endtask

    // Drop the request and wait for all responses; ready returns next cycle.
    task automatic finish_txn();
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        while (exp_rsp.size() != 0 && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (exp_rsp.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: got %0d responses pending, expected 0", exp_rsp.size());
            exp_rsp.delete();
        end else begin
            @(negedge clk);
            #1;
            check("ready_after_resp", {31'd0, req_ready}, 32'd1);
            check("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
        end
    endtask

    task automatic timing_lc4(input logic [27:0] addr);
        int acc_cyc;
        int waited = 0;
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_we    = 1'b0;
        b_req_addr  = addr;
        b_req_be    = 4'b0001;
        b_req_din   = 32'd0;
        #1;
        check("lc4_ready_idle", {31'd0, b_req_ready}, 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        b_req_valid = 1'b0;
        #1;
        while (!b_resp_valid && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("lc4_resp_cycle", cyc, acc_cyc + 8);
        check("lc4_resp_dout", b_resp_dout, {24'd0, {addr[7:2], 2'b00} ^ 8'h5A});
        $display("resp4 cycle=%0d dout=0x%08h", cyc, b_resp_dout);
        @(negedge clk);
        #1;
        check("lc4_ready_cycle", {31'd0, b_req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] ra;
        int          base;
        int          waited;
        bit          held;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_din = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_din = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_dout", resp_dout, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_addr", {4'd0, mem_addr}, 32'd0);
        check("rst_mem_din", {24'd0, mem_din}, 32'd0);
        reset = 1'b0;

        // Four-lane read, all misses
        busy_force = 6;
        issue(1'b0, 28'h0000100, 4'b1111, 32'd0, 1'b0, 1'b1);
        finish_txn();

        // Sparse write
        busy_force = 0;
        issue(1'b1, 28'h0000204, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b1);
        finish_txn();

        // No lanes enabled
        issue(1'b0, 28'h0000300, 4'b0000, 32'd0, 1'b0, 1'b1);
        finish_txn();
        issue(1'b1, 28'h0000304, 4'b0000, 32'h12345678, 1'b0, 1'b1);
        finish_txn();

        // Single-lane hit timing at both gap lengths
        busy_force = 1;
        issue(1'b0, 28'h0000410, 4'b0100, 32'd0, 1'b0, 1'b1);
        finish_txn();
        timing_lc4(28'h0000520);

        // Reset in the WAIT of lane 2 of a four-lane read
        busy_force = 6;
        base = acc_seen;
        issue(1'b0, 28'h0000340, 4'b1111, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        #1;
        while (acc_seen < base + 3 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("lane2_reached", acc_seen, base + 3);
        repeat (3) @(negedge clk);
        check("pre_reset_rd_high", {31'd0, mem_rd}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        check("aborted_lanes_left", exp_acc.size(), 1);
        exp_acc.delete();

        busy_force = 1;
        issue(1'b0, 28'h0000358, 4'b1000, 32'd0, 1'b0, 1'b1);
        finish_txn();

        // Random traffic, sometimes with the request held back to back
        busy_force = 0;
        held = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ra = 28'($urandom);
            issue(1'($urandom), ra, 4'($urandom), $urandom, held, 1'b1);
            held = 1'($urandom_range(0, 1));
            if (!held) finish_txn();
        end
        finish_txn();
        check("acc_queue_empty", exp_acc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
